// File: rtl/regfile_sb_pkg.sv
// regfile_sb shared constants: default widths and the hard-wired zero register.
// Optional same-cycle write bypass is enabled with REGFILE_SB_BYPASS_EN.
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reserve,
// cleared on write; a same-cycle reserve wins over the clearing write.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_enable,
  input  logic [ADDR_W-1:0]    w_addr,
  input  logic                 rsv_enable,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 busy_any
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic clr_hit;
  logic set_hit;

  assign clr_hit = w_enable && (w_addr != ZERO);
  assign set_hit = rsv_enable && (rsv_addr != ZERO);

  // Set is applied after clear so the reserve owns the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_hit) busy[w_addr] <= 1'b0;
      if (set_hit) busy[rsv_addr] <= 1'b1;
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_enable,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     rsv_enable,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  output logic [NUM_RD-1:0]        r_ready,
  output logic                     busy_any
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_hit;

  assign wr_hit = w_enable && (w_addr != ZERO);

  regfile_sb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .rsv_enable (rsv_enable),
    .rsv_addr   (rsv_addr),
    .busy       (busy),
    .busy_any   (busy_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (wr_hit) begin
      mem[w_addr] <= w_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;

    assign ra = r_addr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_SB_BYPASS_EN
    // Held off during reset so outputs stay at their cleared values.
    assign fwd = !reset && wr_hit && (w_addr == ra);
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
      r_data[i*DATA_W +: DATA_W] = '0;
      r_ready[i] = 1'b1;
      if (fwd) begin
`ifdef REGFILE_SB_BYPASS_EN
        r_data[i*DATA_W +: DATA_W] = w_data;
`endif
        r_ready[i] = 1'b1;
      end else if (ra != ZERO) begin
        r_data[i*DATA_W +: DATA_W] = mem[ra];
        r_ready[i] = !busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb (default parameters, 2 ports).
// Expected values follow REGFILE_SB_BYPASS_EN when it is defined.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             reset;
  logic             w_enable;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic             rsv_enable;
  logic [AW-1:0]    rsv_addr;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;
  logic [NR-1:0]    r_ready;
  logic             busy_any;

  int errors = 0;
  int checks = 0;

  regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .rsv_enable (rsv_enable),
    .rsv_addr   (rsv_addr),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .r_ready    (r_ready),
    .busy_any   (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra_s;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    rdy;
    logic          ba;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re,
                       input logic [AW-1:0] rs, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1);
    w_enable   = we;
    w_addr     = wa;
    w_data     = wd;
    rsv_enable = re;
    rsv_addr   = rs;
    r_addr     = {a1, a0};
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic [1:0] rdy,
                            input logic ba);
    check({tag, ".d0"}, 64'(r_data[DW-1:0]), 64'(d0));
    check({tag, ".d1"}, 64'(r_data[2*DW-1:DW]), 64'(d1));
    check({tag, ".rdy"}, 64'(r_ready), 64'(rdy));
    check({tag, ".busy_any"}, 64'(busy_any), 64'(ba));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_d;
  logic          exp_r;

  initial begin
    tv[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2'b11, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0};
    tv[2]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 3, 0, 32'hDEADBEEF, 2'b11, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0};
    tv[4]  = '{0, 0, 0, 1, 9, 9, 3, 0, 32'hDEADBEEF, 2'b11, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 9, 3, 0, 32'hDEADBEEF, 2'b10, 1};
    tv[6]  = '{1, 9, 32'h42, 0, 0, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1};
    tv[7]  = '{0, 0, 0, 0, 0, 9, 0, 32'h42, 0, 2'b11, 0};
    tv[8]  = '{1, 4, 32'h11, 1, 4, 3, 0, 32'hDEADBEEF, 0, 2'b11, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 4, 4, 32'h11, 32'h11, 2'b00, 1};
    tv[10] = '{1, 4, 32'h22, 0, 0, 9, 0, 32'h42, 0, 2'b11, 1};
    tv[11] = '{0, 0, 0, 0, 0, 4, 9, 32'h22, 32'h42, 2'b11, 0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 3, 9);
    #1;
    expect_out("reset", 0, 0, 2'b11, 0);
    step();
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 12; k++) begin
      drive(tv[k].we, tv[k].wa, tv[k].wd, tv[k].re, tv[k].ra_s,
            tv[k].a0, tv[k].a1);
      #2;
      expect_out($sformatf("vec%0d", k), tv[k].d0, tv[k].d1,
                 tv[k].rdy, tv[k].ba);
      step();
    end

    // write lands on a busy register while it is being read
    drive(0, 0, 0, 1, 9, 0, 0);
    step();
    drive(1, 9, 32'h77, 0, 0, 9, 0);
    #2;
`ifdef REGFILE_SB_BYPASS_EN
    exp_d = 32'h77; exp_r = 1'b1;
`else
    exp_d = 32'h42; exp_r = 1'b0;
`endif
    expect_out("wr_busy", exp_d, 0, {1'b1, exp_r}, 1);
    step();
    drive(0, 0, 0, 0, 0, 9, 0);
    #2;
    expect_out("wr_busy_after", 32'h77, 0, 2'b11, 0);
    step();

    // write R12 while reading it
    drive(1, 12, 32'h55, 0, 0, 0, 12);
    #2;
`ifdef REGFILE_SB_BYPASS_EN
    exp_d = 32'h55;
`else
    exp_d = 32'h0;
`endif
    expect_out("byp", 0, exp_d, 2'b11, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 12);
    #2;
    expect_out("byp_after", 0, 32'h55, 2'b11, 0);
    step();

    // write and reserve R12 together while reading it
    drive(1, 12, 32'h66, 1, 12, 12, 0);
    #2;
`ifdef REGFILE_SB_BYPASS_EN
    exp_d = 32'h66;
`else
    exp_d = 32'h55;
`endif
    expect_out("byp_rsv", exp_d, 0, 2'b11, 0);
    step();
    drive(0, 0, 0, 0, 0, 12, 0);
    #2;
    expect_out("byp_rsv_after", 32'h66, 0, 2'b10, 1);
    step();

    // asynchronous reset mid-cycle
    drive(1, 5, 32'h1234, 1, 7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 5, 7);
    #1;
    expect_out("pre_rst", 32'h1234, 0, 2'b01, 1);
    #1;
    reset = 1'b1;
    #1;
    expect_out("mid_rst", 0, 0, 2'b11, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 12, 9);
    #2;
    expect_out("post_rst", 0, 0, 2'b11, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
